// File: rtl/branch_plru_victim_pkg.sv
// Shared types for the BTB pseudo-LRU victim selector.
// Kept separate so other BTB blocks can observe the replace FSM state by name.
package branch_plru_victim_pkg;

    typedef enum logic {
        StIdle,
        StPending
    } state_e;

endpackage

// File: rtl/plru_touch.sv
// Tree pseudo-LRU touch: makes every node on a line's path point away from that line.
// Purely combinational so several touches can be chained within one cycle.
module plru_touch #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned LINE_NUM = 16
) (
    input  logic                  en,
    input  logic [WIDTH-1:0]      index,
    input  logic [LINE_NUM-1:1]   tree_in,
    output logic [LINE_NUM-1:1]   tree_out
);

    logic [WIDTH:0]   leaf;
    logic [WIDTH-1:0] node;

    always_comb begin
        tree_out = tree_in;
        leaf     = {1'b1, index};
        node     = '0;
        if (en) begin
            // Ancestor d levels up is leaf >> d; bit d-1 of the leaf says which child we came from.
            for (int unsigned d = 1; d <= WIDTH; d++) begin
                node           = WIDTH'(leaf >> d);
                tree_out[node] = ~leaf[d-1];
            end
        end
    end

endmodule

// File: rtl/branch_plru_victim.sv
// BTB victim selector: tree pseudo-LRU over all lines, with the chosen line latched
// from the ID-stage replace launch until the EX-stage commit or a flush cancel.
module branch_plru_victim
    import branch_plru_victim_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned LINE_NUM = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             all_valid,
    input  logic [WIDTH-1:0] invalid_index,
    input  logic             hit_en,
    input  logic [WIDTH-1:0] hit_index,
    input  logic             replace_start,
    input  logic             replace_commit,
    input  logic             replace_cancel,
    output logic [WIDTH-1:0] victim_index,
    output logic             victim_valid
);

    localparam int unsigned NODE_NUM = LINE_NUM - 1;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    target_q, target_d;
    logic [WIDTH-1:0]    plru_victim;
    logic [NODE_NUM:1]   tree_q, tree_hit, tree_d;
    logic                commit_touch;

    // Walk from the root; each visited bit is both the next branch and the next victim bit.
    always_comb begin
        logic [WIDTH-1:0] node;
        logic             dir;
        node        = WIDTH'(1);
        dir         = 1'b0;
        plru_victim = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            dir         = tree_q[node];
            plru_victim = {plru_victim[WIDTH-2:0], dir};
            node        = {node[WIDTH-2:0], dir};
        end
    end

    assign commit_touch = (state_q == StPending) && replace_commit && !replace_cancel;

    // Hit first, commit second, so the commit's pointers win on shared nodes.
    plru_touch #(
        .WIDTH    (WIDTH),
        .LINE_NUM (LINE_NUM)
    ) u_touch_hit (
        .en       (hit_en),
        .index    (hit_index),
        .tree_in  (tree_q),
        .tree_out (tree_hit)
    );

    plru_touch #(
        .WIDTH    (WIDTH),
        .LINE_NUM (LINE_NUM)
    ) u_touch_commit (
        .en       (commit_touch),
        .index    (target_q),
        .tree_in  (tree_hit),
        .tree_out (tree_d)
    );

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        unique case (state_q)
            StIdle: begin
                if (replace_start) begin
                    target_d = all_valid ? plru_victim : invalid_index;
                    state_d  = StPending;
                end
            end
            StPending: begin
                if (replace_cancel || replace_commit) begin
                    target_d = '0;
                    state_d  = StIdle;
                end
            end
            default: begin
                target_d = '0;
                state_d  = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            target_q <= '0;
            tree_q   <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            tree_q   <= tree_d;
        end
    end

    assign victim_valid = (state_q == StPending);
    assign victim_index = target_q;

endmodule
